// File: rtl/pblaze_irq_pkg.sv
// Shared types and port map for the PicoBlaze interrupt scheduler.
// Used by the scheduler top and any firmware-facing glue.
package pblaze_irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        WAIT_ACK,
        GAP
    } state_t;

    localparam logic [7:0] IRQ_DATA_PORT = 8'h00;
    localparam logic [7:0] IRQ_ACK_PORT  = 8'h20;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit at or after rr_ptr.
// Wraps modulo NUM_REQ; reusable for any shared PicoBlaze port.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         pending,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Scan offsets from farthest to nearest so the nearest pending index wins.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (pending[idx]) begin
                winner    = IDX_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pblaze_irq_scheduler.sv
// Shares the PicoBlaze interrupt line and input port 0x00 among event sources.
// Captures event bytes, grants round-robin, holds the winner until acknowledged.
module pblaze_irq_scheduler
    import pblaze_irq_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        irq_ack,
    input  logic                        flag_clr,
    output logic                        interr_sig,
    output logic [DATA_W-1:0]           input_data,
    output logic [2:0]                  src_id,
    output logic                        busy,
    output logic [NUM_REQ-1:0]          overrun,
    output logic                        timeout_flag
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int CNT_MAX   = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ?
                               TIMEOUT_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int TMO_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int HOLD_LAST = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [DATA_W-1:0]    hold_q [NUM_REQ];
    logic [DATA_W-1:0]    hold_d [NUM_REQ];
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 irq_q, irq_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [2:0]           src_q, src_d;
    logic [NUM_REQ-1:0]   ovr_q, ovr_d;
    logic                 tmo_q, tmo_d;

    logic [IDX_W-1:0]     arb_win;
    logic                 arb_any;
    logic [IDX_W-1:0]     gnt_next;
    logic                 ack_clr;
    logic                 tmo_set;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .pending   (pending_q),
        .rr_ptr    (rr_q),
        .winner    (arb_win),
        .any_valid (arb_any)
    );

    // Pointer to the source after the current grant, wrapping at NUM_REQ.
    always_comb begin
        gnt_next = gnt_q + 1'b1;
        if (int'(gnt_q) == NUM_REQ - 1) begin
            gnt_next = '0;
        end
    end

    // Grant FSM: next state, grant latch, counter and interrupt pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = 1'b0;
        data_d  = data_q;
        src_d   = src_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        ack_clr = 1'b0;
        tmo_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    data_d  = hold_q[arb_win];
                    src_d   = 3'(arb_win);
                    gnt_d   = arb_win;
                    irq_d   = 1'b1;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (irq_ack) begin
                    ack_clr = 1'b1;
                    rr_d    = gnt_next;
                    cnt_d   = '0;
                    state_d = (HOLDOFF_CYCLES == 0) ? IDLE : GAP;
                end else if (cnt_q == CNT_W'(TMO_LAST)) begin
                    tmo_set = 1'b1;
                    rr_d    = gnt_next;
                    cnt_d   = '0;
                    state_d = (HOLDOFF_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(HOLD_LAST)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Event capture and sticky flags; a new strobe beats a same-cycle clear.
    always_comb begin
        pending_d = pending_q;
        if (ack_clr) begin
            pending_d[gnt_q] = 1'b0;
        end
        pending_d = pending_d | req;
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_d[i] = req[i] ? req_data[i*DATA_W +: DATA_W] : hold_q[i];
        end
        ovr_d = (flag_clr ? '0 : ovr_q) | (req & pending_q);
        tmo_d = (flag_clr ? 1'b0 : tmo_q) | tmo_set;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= '0;
            end
            rr_q      <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
            data_q    <= '0;
            src_q     <= '0;
            ovr_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= hold_d[i];
            end
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
            data_q    <= data_d;
            src_q     <= src_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
        end
    end

    assign interr_sig   = irq_q;
    assign input_data   = data_q;
    assign src_id       = src_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = ovr_q;
    assign timeout_flag = tmo_q;

endmodule

// File: tb/tb_pblaze_irq_scheduler.sv
// Randomized scoreboard bench for pblaze_irq_scheduler.
// Reference model tracks pending set, bytes, round-robin pointer and flags.
module tb_pblaze_irq_scheduler;

    localparam int N    = 4;
    localparam int TMO  = 50;
    localparam int HOLD = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*8-1:0] req_data = '0;
    logic          irq_ack = 1'b0;
    logic          flag_clr = 1'b0;
    logic          interr_sig;
    logic [7:0]    input_data;
    logic [2:0]    src_id;
    logic          busy;
    logic [N-1:0]  overrun;
    logic          timeout_flag;

    always #5 clk = ~clk;

    pblaze_irq_scheduler #(
        .NUM_REQ        (N),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (TMO),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_data     (req_data),
        .irq_ack      (irq_ack),
        .flag_clr     (flag_clr),
        .interr_sig   (interr_sig),
        .input_data   (input_data),
        .src_id       (src_id),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_flag (timeout_flag)
    );

    typedef struct {
        int         src;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fails = 0;
    logic [N-1:0] m_pend = '0;
    logic [7:0] m_hold [N];
    int         m_rr = 0;
    logic [N-1:0] m_ovr = '0;
    logic       m_tmo = 1'b0;
    int         m_gnt = 0;
    int         cyc = 0;
    int         last_pulse = -1;
    bit         have = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic push_next(output bit got);
        int   w;
        exp_t e;
        w = pick();
        got = (w >= 0);
        if (got) begin
            e.src  = w;
            e.data = m_hold[w];
            exp_q.push_back(e);
            m_gnt = w;
        end
    endtask

    task automatic step(input logic [N-1:0] m, input logic [N*8-1:0] d,
                        input logic ack, input logic clr);
        logic [N-1:0] old;
        req      = m;
        req_data = d;
        irq_ack  = ack;
        flag_clr = clr;
        old = m_pend;
        if (ack) begin
            m_pend[m_gnt] = 1'b0;
            m_rr = (m_gnt + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                m_pend[i] = 1'b1;
                m_hold[i] = d[i*8 +: 8];
            end
        end
        if (clr) begin
            m_ovr = '0;
            m_tmo = 1'b0;
        end
        m_ovr = m_ovr | (m & old);
        @(negedge clk);
        req      = '0;
        req_data = '0;
        irq_ack  = 1'b0;
        flag_clr = 1'b0;
    endtask

    task automatic mon();
        exp_t e;
        cyc++;
        if (!reset_n) begin
            last_pulse = -1;
            return;
        end
        if (interr_sig) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_irq: got src %0d data %0h, none expected",
                         src_id, input_data);
            end else begin
                e = exp_q.pop_front();
                chk("grant_src", 32'(src_id), e.src);
                chk("grant_data", 32'(input_data), 32'(e.data));
                chk("busy_at_irq", 32'(busy), 1);
            end
            if (last_pulse >= 0) begin
                chk("irq_gap", 32'((cyc - last_pulse) >= HOLD + 2), 1);
            end
            last_pulse = cyc;
        end
    endtask

    task automatic wait_irq();
        int n;
        n = 0;
        while (!interr_sig && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("irq_arrived", 32'(interr_sig), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("went_idle", 32'(busy), 0);
    endtask

    task automatic chk_flags();
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("timeout_flag", 32'(timeout_flag), 32'(m_tmo));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_irq"}, 32'(interr_sig), 0);
        chk({tag, "_data"}, 32'(input_data), 0);
        chk({tag, "_src"}, 32'(src_id), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_tmo"}, 32'(timeout_flag), 0);
    endtask

    initial begin
        int n;
        logic [N-1:0] m;
        logic [N*8-1:0] d;
        for (int i = 0; i < N; i++) m_hold[i] = '0;
        fork
            forever begin
                @(negedge clk);
                mon();
            end
        join_none

        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // single event, latency and holdoff length
        step(4'b0100, 32'h005A_0000, 1'b0, 1'b0);
        push_next(have);
        chk("lat_not_early", 32'(interr_sig), 0);
        @(negedge clk);
        chk("lat_two", 32'(interr_sig), 1);
        chk("busy_fire", 32'(busy), 1);
        step('0, '0, 1'b0, 1'b0);
        chk("data_held", 32'(input_data), 32'h5A);
        step('0, '0, 1'b1, 1'b0);
        push_next(have);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("gap_len", n, HOLD);

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            if (!have) begin
                wait_idle();
                m = (r == 0) ? 4'hF : 4'($urandom_range(1, 15));
                d = (r == 0) ? 32'h1312_1110 : 32'($urandom);
                step(m, d, 1'b0, 1'b0);
                push_next(have);
            end
            wait_irq();
            if ($urandom_range(0, 5) == 0) begin
                step('0, '0, 1'b0, 1'b1);
                n = 0;
                while (!timeout_flag && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("tmo_latency", n, TMO);
                m_tmo = 1'b1;
                m_rr = (m_gnt + 1) % N;
                chk_flags();
                push_next(have);
            end else begin
                n = $urandom_range(1, 8);
                for (int j = 0; j < n; j++) begin
                    m = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : '0;
                    step(m, 32'($urandom), 1'b0, ($urandom_range(0, 7) == 0));
                end
                m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : '0;
                step(m, 32'($urandom), 1'b1, ($urandom_range(0, 5) == 0));
                chk_flags();
                push_next(have);
            end
        end

        // reset during WAIT_ACK
        if (!have) begin
            wait_idle();
            step(4'b0010, 32'h0000_C300, 1'b0, 1'b0);
            push_next(have);
        end
        wait_irq();
        step('0, '0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        exp_q.delete();
        m_pend = '0;
        m_rr = 0;
        m_ovr = '0;
        m_tmo = 1'b0;
        for (int i = 0; i < N; i++) m_hold[i] = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (interr_sig) n++;
        end
        chk("no_irq_after_rst", n, 0);
        step(4'b1000, 32'h7700_0000, 1'b0, 1'b0);
        push_next(have);
        wait_irq();
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        push_next(have);
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pblaze_irq_scheduler.md
Name: pblaze_irq_scheduler

Overview:
- Shares the single PicoBlaze interrupt line and the single input port (port 0x00) between NUM_REQ event sources, e.g. sample-rate tick, keypad and song-end.
- Captures each source's 8-bit event byte and arbitrates round-robin among pending sources.
- Drives the one-cycle `interr_sig` pulse and holds the winner's byte plus source ID stable until firmware acknowledges.
- Sits between the event sources and the PicoBlaze wrapper's `interr_sig`/`input_data` inputs.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- DATA_W, 8: event byte width; fixed to the PicoBlaze port width.
- TIMEOUT_CYCLES, 1000000: cycles to wait for `irq_ack` before abandoning the current grant.
- HOLDOFF_CYCLES, 16: minimum idle gap after a grant ends, before the next `interr_sig`.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-source event strobe; one-cycle pulse, sampled on the rising edge.
- req_data  in  NUM_REQ*DATA_W  packed event bytes; source i occupies bits [i*8+7:i*8] and is valid with req[i].
- irq_ack  in  1  one-cycle pulse from the firmware ack port decode.
- flag_clr  in  1  clears the overrun and timeout sticky flags.
- interr_sig  out  1  one-cycle interrupt pulse to the PicoBlaze wrapper.
- input_data  out  8  byte of the granted source.
- src_id  out  3  index of the granted source.
- busy  out  1  high in every state except IDLE.
- overrun  out  NUM_REQ  sticky per source: req arrived while that source was already pending.
- timeout_flag  out  1  sticky: a grant expired without ack.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; pending=0; hold registers=0; rr_ptr=0; counter=0.
  - All outputs 0.
- Capture: on req[i], pending[i]<=1 and hold[i]<=req_data slice.
  - If pending[i] was already 1: hold[i] is overwritten (newest byte wins) and overrun[i]<=1.
- State IDLE:
  - If any pending: pick the first pending index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch input_data<=hold[winner], src_id<=winner, gnt<=winner; go FIRE.
  - Latency: req at edge t → pending at t+1 → grant latched at edge t+1 → interr_sig high during cycle t+2. That is 2 cycles from strobe to interrupt when idle.
- State FIRE:
  - interr_sig=1 for exactly this one cycle; counter<=0; go WAIT_ACK.
- State WAIT_ACK:
  - interr_sig=0; input_data and src_id are held stable. Later captures update hold[], never input_data.
  - irq_ack: clear pending[gnt] (unless a req[gnt] arrives in the same cycle, in which case it stays set with the new byte); rr_ptr<=gnt+1 mod NUM_REQ; go GAP.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: pending[gnt] is kept, so the source is retried later; timeout_flag<=1; rr_ptr<=gnt+1 so other sources are served first; go GAP.
  - irq_ack and timeout in the same cycle: ack wins, no flag.
- State GAP:
  - Count HOLDOFF_CYCLES cycles, then go IDLE.
  - If HOLDOFF_CYCLES=0, go directly to IDLE.
- Ignored inputs:
  - irq_ack outside WAIT_ACK has no effect.
  - flag_clr takes effect in any state; a flag set in the same cycle as flag_clr wins (set dominates).
- Widths:
  - src_id is zero-extended to 3 bits.
  - Counter width = $clog2(max(TIMEOUT_CYCLES, HOLDOFF_CYCLES)+1).
- Reset mid-WAIT_ACK drops all pending events with no interr_sig glitch, because interr_sig is a registered output.

Decomposition:
- Package pblaze_irq_pkg holds:
  - state enum {IDLE, FIRE, WAIT_ACK, GAP};
  - port constant IRQ_DATA_PORT=8'h00;
  - port constant IRQ_ACK_PORT=8'h20.
- One sub-module: rr_arbiter. Purely combinational; inputs pending and rr_ptr; outputs winner index and any_valid. It is reused later for other shared ports.

Test Plan:
- Single event: req[2] with data 0x5A → interr_sig pulses 2 cycles later; input_data=0x5A, src_id=2, busy=1; irq_ack → GAP for 16 cycles → IDLE, busy=0.
- Round-robin: req[0..3] strobed in the same cycle (data 0x10/0x11/0x12/0x13), ack each grant → grants in order 0,1,2,3, with ≥16-cycle gaps between interr_sig pulses.
- Fairness: after granting source 1, keep sources 1 and 3 pending → next grant is 3, then 1.
- Overrun: req[1]=0xAA, then req[1]=0xBB before grant → single interrupt with 0xBB; overrun[1]=1; flag_clr → overrun=0.
- Timeout: TIMEOUT_CYCLES=50, no ack → timeout_flag=1 at cycle 50 after FIRE; source re-presented after other pending sources are served.
- Reset: assert reset_n=0 during WAIT_ACK → all outputs 0 immediately; no interr_sig after release until a new req arrives.
